// File: rtl/sm_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_event_pkg
// Brief    : Shared supervisory-state encodings and counter-width default.
// Revision : 1.0
// ============================================================================
package sm_event_pkg;

   localparam int c_CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_ALARM = 2'd2
   } sup_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear taking priority.
// Revision : 1.0
// ============================================================================
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] c_MAX = {W{1'b1}};

   logic [W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc && (r_q != c_MAX)) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/sm_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sm_event_monitor
// Brief    : Counts control-FSM events, escalates persistent err into a
//            sticky alarm, and exposes counter snapshots via req/ack.
// Revision : 1.0
// ============================================================================
module sm_event_monitor
   import sm_event_pkg::*;
#(
   parameter int CNT_W     = c_CNT_W_DEFAULT,
   parameter int ERR_LIMIT = 3,
   parameter int QUIET     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             o1_in,
   input  logic             o2_in,
   input  logic             err_in,
   input  logic             clr,
   input  logic             rd_req,
   output logic             rd_ack,
   output logic [CNT_W-1:0] o1_cnt,
   output logic [CNT_W-1:0] o2_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       state_out,
   output logic             alarm
);

   localparam logic [3:0] c_ERR_LIMIT = 4'(ERR_LIMIT);
   localparam logic [3:0] c_QUIET     = 4'(QUIET);

   logic             r_o1_prev;
   logic             r_o2_prev;
   logic             r_rd_prev;
   logic             r_rd_ack;
   logic             r_alarm;
   logic [CNT_W-1:0] r_o1_snap;
   logic [CNT_W-1:0] r_o2_snap;
   logic [CNT_W-1:0] r_err_snap;
   logic [CNT_W-1:0] w_o1_q;
   logic [CNT_W-1:0] w_o2_q;
   logic [CNT_W-1:0] w_err_q;
   logic             w_rd_rise;

   sup_state_t r_state;
   sup_state_t w_state_nxt;
   logic [3:0] r_run;
   logic [3:0] r_quiet;
   logic [3:0] w_run_nxt;
   logic [3:0] w_quiet_nxt;
   logic [3:0] w_run_inc;
   logic [3:0] w_quiet_inc;

   assign w_rd_rise   = rd_req & ~r_rd_prev;
   assign w_run_inc   = r_run + 4'd1;
   assign w_quiet_inc = r_quiet + 4'd1;

   sat_counter #(.W(CNT_W)) u_o1_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (o1_in & ~r_o1_prev),
      .q   (w_o1_q)
   );

   sat_counter #(.W(CNT_W)) u_o2_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (o2_in & ~r_o2_prev),
      .q   (w_o2_q)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (err_in),
      .q   (w_err_q)
   );

   // Snapshots take the pre-update counter values, so a read coinciding
   // with clr still reports what was accumulated before the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_o1_prev  <= 1'b0;
         r_o2_prev  <= 1'b0;
         r_rd_prev  <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_o1_snap  <= '0;
         r_o2_snap  <= '0;
         r_err_snap <= '0;
      end else begin
         r_o1_prev <= o1_in;
         r_o2_prev <= o2_in;
         r_rd_prev <= rd_req;
         r_rd_ack  <= w_rd_rise;
         if (w_rd_rise) begin
            r_o1_snap  <= w_o1_q;
            r_o2_snap  <= w_o2_q;
            r_err_snap <= w_err_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_run   <= 4'd0;
         r_quiet <= 4'd0;
         r_alarm <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_quiet <= w_quiet_nxt;
         r_alarm <= (w_state_nxt == ST_ALARM);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_quiet_nxt = r_quiet;
      if (clr) begin
         w_state_nxt = ST_IDLE;
         w_run_nxt   = 4'd0;
         w_quiet_nxt = 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (err_in) begin
                  w_state_nxt = ST_WARN;
                  w_run_nxt   = 4'd1;
                  w_quiet_nxt = 4'd0;
               end
            end
            ST_WARN: begin
               if (err_in) begin
                  w_quiet_nxt = 4'd0;
                  w_run_nxt   = w_run_inc;
                  if (w_run_inc == c_ERR_LIMIT) w_state_nxt = ST_ALARM;
               end else begin
                  w_run_nxt   = 4'd0;
                  w_quiet_nxt = w_quiet_inc;
                  if (w_quiet_inc == c_QUIET) w_state_nxt = ST_IDLE;
               end
            end
            ST_ALARM: begin
               w_state_nxt = ST_ALARM;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign rd_ack    = r_rd_ack;
   assign o1_cnt    = r_o1_snap;
   assign o2_cnt    = r_o2_snap;
   assign err_cnt   = r_err_snap;
   assign state_out = r_state;
   assign alarm     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_sm_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_event_monitor
// Brief    : Directed vector table, multi-cycle corner sequences and random
//            stimulus against a count-based reference model.
// Revision : 1.0
// ============================================================================
module tb_sm_event_monitor;

   localparam int ERR_LIMIT = 3;
   localparam int QUIET     = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic o1_in = 1'b0, o2_in = 1'b0, err_in = 1'b0, clr = 1'b0, rd_req = 1'b0;

   logic       a_ack, b_ack, a_alarm, b_alarm;
   logic [7:0] a_o1, a_o2, a_err;
   logic [3:0] b_o1, b_o2, b_err;
   logic [1:0] a_st, b_st;

   always #5 clk = ~clk;

   sm_event_monitor #(.CNT_W(8), .ERR_LIMIT(ERR_LIMIT), .QUIET(QUIET)) dut8 (
      .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
      .clr(clr), .rd_req(rd_req), .rd_ack(a_ack), .o1_cnt(a_o1),
      .o2_cnt(a_o2), .err_cnt(a_err), .state_out(a_st), .alarm(a_alarm)
   );

   sm_event_monitor #(.CNT_W(4), .ERR_LIMIT(ERR_LIMIT), .QUIET(QUIET)) dut4 (
      .clk(clk), .rst(rst), .o1_in(o1_in), .o2_in(o2_in), .err_in(err_in),
      .clr(clr), .rd_req(rd_req), .rd_ack(b_ack), .o1_cnt(b_o1),
      .o2_cnt(b_o2), .err_cnt(b_err), .state_out(b_st), .alarm(b_alarm)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: raw event totals since last clear, saturated on view.
   int m_c1, m_c2, m_ce, m_s1, m_s2, m_se;
   int m_state, m_run, m_quiet;
   bit m_p1, m_p2, m_prd, m_ack;

   function automatic int sat(input int x, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   task automatic model_reset();
      m_c1 = 0; m_c2 = 0; m_ce = 0; m_s1 = 0; m_s2 = 0; m_se = 0;
      m_state = 0; m_run = 0; m_quiet = 0;
      m_p1 = 0; m_p2 = 0; m_prd = 0; m_ack = 0;
   endtask

   task automatic model_edge(input bit a, input bit b, input bit e, input bit c, input bit r);
      m_ack = r && !m_prd;
      if (m_ack) begin
         m_s1 = m_c1; m_s2 = m_c2; m_se = m_ce;
      end
      if (c) begin
         m_c1 = 0; m_c2 = 0; m_ce = 0;
         m_state = 0; m_run = 0; m_quiet = 0;
      end else begin
         if (a && !m_p1) m_c1++;
         if (b && !m_p2) m_c2++;
         if (e) m_ce++;
         if (m_state == 0) begin
            if (e) begin m_state = 1; m_run = 1; m_quiet = 0; end
         end else if (m_state == 1) begin
            if (e) begin
               m_quiet = 0; m_run++;
               if (m_run == ERR_LIMIT) m_state = 2;
            end else begin
               m_run = 0; m_quiet++;
               if (m_quiet == QUIET) m_state = 0;
            end
         end
      end
      m_p1 = a; m_p2 = b; m_prd = r;
   endtask

   task automatic step(input bit a, input bit b, input bit e, input bit c, input bit r);
      o1_in = a; o2_in = b; err_in = e; clr = c; rd_req = r;
      @(posedge clk);
      model_edge(a, b, e, c, r);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      o1_in = 0; o2_in = 0; err_in = 0; clr = 0; rd_req = 0;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_ack", a_ack, 0);
      check("rst_state", a_st, 0);
      check("rst_alarm", a_alarm, 0);
      check("rst_snaps", {a_o1, a_o2, a_err}, 0);
      rst = 1'b0;
   endtask

   task automatic model_compare(input string tag);
      check({tag, "_ack8"}, a_ack, m_ack);
      check({tag, "_ack4"}, b_ack, m_ack);
      check({tag, "_state8"}, a_st, m_state);
      check({tag, "_state4"}, b_st, m_state);
      check({tag, "_alarm8"}, a_alarm, (m_state == 2));
      check({tag, "_alarm4"}, b_alarm, (m_state == 2));
      check({tag, "_snap8"}, {a_o1, a_o2, a_err},
            {8'(sat(m_s1, 8)), 8'(sat(m_s2, 8)), 8'(sat(m_se, 8))});
      check({tag, "_snap4"}, {b_o1, b_o2, b_err},
            {4'(sat(m_s1, 4)), 4'(sat(m_s2, 4)), 4'(sat(m_se, 4))});
   endtask

   typedef struct {
      bit       o1, o2, err, clr, rd;
      bit [1:0] st;
      bit       al, ack;
      bit [7:0] c1, c2, ce;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit o1, bit o2, bit err, bit c, bit rd, bit [1:0] st,
                               bit al, bit ack, bit [7:0] c1, bit [7:0] c2, bit [7:0] ce);
      vec_t v;
      v.o1 = o1; v.o2 = o2; v.err = err; v.clr = c; v.rd = rd;
      v.st = st; v.al = al; v.ack = ack; v.c1 = c1; v.c2 = c2; v.ce = ce;
      tbl.push_back(v);
   endfunction

   initial begin
      // idle read
      add(0,0,0,0,1, 0,0,1, 0,0,0);
      add(0,0,0,0,0, 0,0,0, 0,0,0);
      // o1: 1,1,1,0,1,1  o2: -,1,0,1,0
      add(1,0,0,0,0, 0,0,0, 0,0,0);
      add(1,1,0,0,0, 0,0,0, 0,0,0);
      add(1,0,0,0,0, 0,0,0, 0,0,0);
      add(0,1,0,0,0, 0,0,0, 0,0,0);
      add(1,0,0,0,0, 0,0,0, 0,0,0);
      add(1,0,0,0,0, 0,0,0, 0,0,0);
      add(0,0,0,0,1, 0,0,1, 2,2,0);
      add(0,0,0,0,0, 0,0,0, 2,2,0);
      // short err burst, then quiet back to IDLE
      add(0,0,1,0,0, 1,0,0, 2,2,0);
      add(0,0,1,0,0, 1,0,0, 2,2,0);
      add(0,0,0,0,0, 1,0,0, 2,2,0);
      add(0,0,0,0,0, 1,0,0, 2,2,0);
      add(0,0,0,0,0, 1,0,0, 2,2,0);
      add(0,0,0,0,0, 0,0,0, 2,2,0);
      add(0,0,0,0,1, 0,0,1, 2,2,2);
      add(0,0,0,0,0, 0,0,0, 2,2,2);
      // escalation to sticky ALARM, then clr
      add(0,0,1,0,0, 1,0,0, 2,2,2);
      add(0,0,1,0,0, 1,0,0, 2,2,2);
      add(0,0,1,0,0, 2,1,0, 2,2,2);
      for (int i = 0; i < 10; i++) add(0,0,0,0,0, 2,1,0, 2,2,2);
      add(0,0,0,1,0, 0,0,0, 2,2,2);
      add(0,0,0,0,1, 0,0,1, 0,0,0);
      add(0,0,0,0,0, 0,0,0, 0,0,0);
      // five o1 events, then read coinciding with clr
      for (int i = 0; i < 5; i++) begin
         add(1,0,0,0,0, 0,0,0, 0,0,0);
         add(0,0,0,0,0, 0,0,0, 0,0,0);
      end
      add(0,0,0,1,1, 0,0,1, 5,0,0);
      add(0,0,0,0,0, 0,0,0, 5,0,0);
      add(0,0,0,0,1, 0,0,1, 0,0,0);
      add(0,0,0,0,0, 0,0,0, 0,0,0);

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].o1, tbl[i].o2, tbl[i].err, tbl[i].clr, tbl[i].rd);
         check($sformatf("vec%0d_ack", i), a_ack, tbl[i].ack);
         check($sformatf("vec%0d_state", i), a_st, tbl[i].st);
         check($sformatf("vec%0d_alarm", i), a_alarm, tbl[i].al);
         check($sformatf("vec%0d_snap", i), {a_o1, a_o2, a_err},
               {tbl[i].c1, tbl[i].c2, tbl[i].ce});
      end

      // saturation on the narrow instance, then reset with an ack in flight
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
      check("sat_state", a_st, 2);
      step(0, 0, 1, 0, 1);
      check("sat_err4", b_err, 15);
      check("sat_err8", a_err, 20);
      check("sat_ack", b_ack, 1);
      check("sat_alarm", b_alarm, 1);
      rst = 1'b1;
      #1;
      check("midrst_ack", {a_ack, b_ack}, 0);
      check("midrst_alarm", {a_alarm, b_alarm}, 0);
      check("midrst_state", a_st, 0);
      check("midrst_snap", {b_o1, b_o2, b_err}, 0);
      rst = 1'b0;
      model_reset();

      // random stimulus with bursty err so escalation is reached
      begin
         bit e_burst;
         e_burst = 0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) e_burst = !e_burst;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 e_burst ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0));
            model_compare("rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
